rv32i_top: RTL and testbench

//  Single-cycle RV32I integer core with internal instruction ROM and data RAM.
//  It is the top of the CPU design: it fetches, decodes, executes and writes back one instruction per clock.
//  The current instruction word and the full register file are exported for bench observation.

---
 rtl/rv32i_top.sv | 165 ++++++++++++++++
 tb/tb_rv32i_top.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_top.sv
// rv32i_top: single-cycle RV32I core with internal instruction ROM and data RAM.
// Define RV_MUL_EN to execute MUL/MULH/MULHSU/MULHU; otherwise funct7=0000001 OPs are NOPs.
module rv32i_top #(
    parameter int unsigned IMEM_WORDS = 256,
    parameter int unsigned DMEM_WORDS = 256,
    parameter string       IMEM_FILE  = "program.hex",
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic [31:0]       instr1,
    output logic [31:0][31:0] regs
);
    localparam int unsigned IA = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
    localparam int unsigned DA = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

    logic [31:0] imem [IMEM_WORDS];
    logic [31:0] dmem [DMEM_WORDS];

    // Power-up contents: zeroed ROM and RAM.
    initial begin
        for (int unsigned i = 0; i < IMEM_WORDS; i++) imem[i] = '0;
        for (int unsigned i = 0; i < DMEM_WORDS; i++) dmem[i] = '0;
    end

    logic [31:0]       pc_q, pc_d;
    logic [31:0][31:0] rf_q, rf_d;
    logic [31:0]       instr, rs1_val, rs2_val;
    logic [31:0]       imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [6:0]        opcode, funct7;
    logic [2:0]        funct3;
    logic [4:0]        rd;
    logic [31:0]       daddr, load_data, wb_data, alu_b, alu_res;
    logic              dmem_hit, wb_en, mem_we, br_taken, alu_alt;
    logic              unused_bits;

    assign instr   = (pc_q[31:2] < 30'(IMEM_WORDS)) ? imem[pc_q[IA+1:2]] : 32'h0;
    assign instr1  = instr;
    assign regs    = rf_q;

    assign opcode  = instr[6:0];
    assign rd      = instr[11:7];
    assign funct3  = instr[14:12];
    assign funct7  = instr[31:25];
    assign rs1_val = rf_q[instr[19:15]];
    assign rs2_val = rf_q[instr[24:20]];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'h000};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    assign daddr     = rs1_val + ((opcode == 7'b0100011) ? imm_s : imm_i);
    assign dmem_hit  = daddr[31:2] < 30'(DMEM_WORDS);
    assign load_data = dmem_hit ? dmem[daddr[DA+1:2]] : 32'h0;

    // OP-IMM only honours the alternate encoding for SRAI; ADDI never subtracts.
    assign alu_b   = (opcode == 7'b0110011) ? rs2_val : imm_i;
    assign alu_alt = (opcode == 7'b0110011) ? funct7[5] : (funct3 == 3'b101) && funct7[5];

`ifdef RV_MUL_EN
    logic signed [65:0] mul_a, mul_b, mul_prod;
    logic               mul_a_sgn, mul_b_sgn;
    logic [31:0]        mul_res;
    assign mul_a_sgn = (funct3 == 3'b001) || (funct3 == 3'b010);
    assign mul_b_sgn = (funct3 == 3'b001);
    assign mul_a     = {{34{mul_a_sgn & rs1_val[31]}}, rs1_val};
    assign mul_b     = {{34{mul_b_sgn & rs2_val[31]}}, rs2_val};
    assign mul_prod  = mul_a * mul_b;
    assign mul_res   = (funct3 == 3'b000) ? mul_prod[31:0] : mul_prod[63:32];
    assign unused_bits = ^{daddr[1:0], mul_prod[65:64]};
`else
    assign unused_bits = ^daddr[1:0];
`endif

    always_comb begin
        alu_res = '0;
        case (funct3)
            3'b000: alu_res = alu_alt ? rs1_val - alu_b : rs1_val + alu_b;
            3'b001: alu_res = rs1_val << alu_b[4:0];
            3'b010: alu_res = {31'b0, $signed(rs1_val) < $signed(alu_b)};
            3'b011: alu_res = {31'b0, rs1_val < alu_b};
            3'b100: alu_res = rs1_val ^ alu_b;
            3'b101: begin
                if (alu_alt) alu_res = $signed(rs1_val) >>> alu_b[4:0];
                else         alu_res = rs1_val >> alu_b[4:0];
            end
            3'b110: alu_res = rs1_val | alu_b;
            3'b111: alu_res = rs1_val & alu_b;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000: br_taken = rs1_val == rs2_val;
            3'b001: br_taken = rs1_val != rs2_val;
            3'b100: br_taken = $signed(rs1_val) < $signed(rs2_val);
            3'b101: br_taken = $signed(rs1_val) >= $signed(rs2_val);
            3'b110: br_taken = rs1_val < rs2_val;
            3'b111: br_taken = rs1_val >= rs2_val;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        pc_d    = pc_q + 32'd4;
        rf_d    = rf_q;
        wb_en   = 1'b0;
        wb_data = '0;
        mem_we  = 1'b0;
        case (opcode)
            7'b0110111: begin wb_en = 1'b1; wb_data = imm_u; end
            7'b0010111: begin wb_en = 1'b1; wb_data = pc_q + imm_u; end
            7'b1101111: begin
                wb_en = 1'b1; wb_data = pc_q + 32'd4; pc_d = pc_q + imm_j;
            end
            7'b1100111: begin
                if (funct3 == 3'b000) begin
                    wb_en = 1'b1; wb_data = pc_q + 32'd4; pc_d = (rs1_val + imm_i) & ~32'd1;
                end
            end
            7'b1100011: if (br_taken) pc_d = pc_q + imm_b;
            7'b0000011: if (funct3 == 3'b010) begin wb_en = 1'b1; wb_data = load_data; end
            7'b0100011: mem_we = (funct3 == 3'b010) && dmem_hit;
            7'b0010011: begin
                if ((funct3 != 3'b001 && funct3 != 3'b101) || funct7 == 7'b0000000 ||
                    (funct3 == 3'b101 && funct7 == 7'b0100000)) begin
                    wb_en = 1'b1; wb_data = alu_res;
                end
            end
            7'b0110011: begin
                if (funct7 == 7'b0000000 ||
                    (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                    wb_en = 1'b1; wb_data = alu_res;
                end
`ifdef RV_MUL_EN
                else if (funct7 == 7'b0000001 && !funct3[2]) begin
                    wb_en = 1'b1; wb_data = mul_res;
                end
`endif
            end
            default: ;
        endcase
        // Halt sentinel: hold PC forever.
        if (instr == 32'h0) pc_d = pc_q;
        if (wb_en && rd != 5'd0) rf_d[rd] = wb_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
            rf_q <= '0;
        end else begin
            pc_q <= pc_d;
            rf_q <= rf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && mem_we) dmem[daddr[DA+1:2]] <= rs2_val;
    end
endmodule

// File: tb/tb_rv32i_top.sv
// Bench for rv32i_top: directed programs plus random instruction streams, all run in
// lockstep against an instruction-level interpreter of the ISA.
module tb_rv32i_top;
    localparam int unsigned IW = 256;
    localparam int unsigned DW = 256;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [31:0]       instr1;
    logic [31:0][31:0] regs;
    int                n_checks = 0;
    int                n_errors = 0;

    rv32i_top #(
        .IMEM_WORDS(IW),
        .DMEM_WORDS(DW),
        .IMEM_FILE (""),
        .RESET_PC  (32'h0)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .instr1(instr1),
        .regs  (regs)
    );

    always #5 clk = ~clk;

    // Reference interpreter state.
    logic [31:0] prog[$];
    logic [31:0] img [IW];
    logic [31:0] m_pc;
    logic [31:0] m_x [32];
    bit   [31:0] m_mem [int unsigned];

    function automatic logic [31:0] enc_i(logic [31:0] imm, logic [31:0] rs1, logic [31:0] f3,
                                          logic [31:0] rd, logic [6:0] op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
    endfunction
    function automatic logic [31:0] enc_r(logic [31:0] f7, logic [31:0] rs2, logic [31:0] rs1,
                                          logic [31:0] f3, logic [31:0] rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction
    function automatic logic [31:0] enc_s(logic [31:0] imm, logic [31:0] rs2, logic [31:0] rs1,
                                          logic [31:0] f3);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(logic [31:0] imm, logic [31:0] rs2, logic [31:0] rs1,
                                          logic [31:0] f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_u(logic [31:0] imm, logic [31:0] rd, logic [6:0] op);
        return {imm[19:0], rd[4:0], op};
    endfunction
    function automatic logic [31:0] enc_j(logic [31:0] imm, logic [31:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
    endfunction

    function automatic logic [31:0] m_fetch();
        if ((m_pc >> 2) < IW) return img[m_pc[9:2]];
        return 32'h0;
    endfunction

    function automatic int first_diff();
        for (int i = 0; i < 32; i++) if (regs[i] !== m_x[i]) return i;
        return -1;
    endfunction

    task automatic m_reset();
        m_pc = 32'h0;
        for (int i = 0; i < 32; i++) m_x[i] = 32'h0;
    endtask

    task automatic m_step();
        logic [31:0] w, a, b, res, nxt, addr, immi, imms, immb, immu, immj;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic [4:0]  rd;
        bit          wr, tk;
        longint      sp;
        longint unsigned up;
        w = m_fetch();
        if (w == 32'h0) return;
        op = w[6:0]; rd = w[11:7]; f3 = w[14:12]; f7 = w[31:25];
        a = m_x[w[19:15]]; b = m_x[w[24:20]];
        immi = 32'($signed(w[31:20]));
        imms = 32'($signed({w[31:25], w[11:7]}));
        immb = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
        immu = {w[31:12], 12'h0};
        immj = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
        res = 32'h0; wr = 0; tk = 0; nxt = m_pc + 32'd4;
        case (op)
            7'h37: begin res = immu; wr = 1; end
            7'h17: begin res = m_pc + immu; wr = 1; end
            7'h6f: begin res = m_pc + 4; wr = 1; nxt = m_pc + immj; end
            7'h67: if (f3 == 3'd0) begin res = m_pc + 4; wr = 1; nxt = (a + immi) & ~32'h1; end
            7'h63: begin
                case (f3)
                    3'd0: tk = (a == b);
                    3'd1: tk = (a != b);
                    3'd4: tk = ($signed(a) < $signed(b));
                    3'd5: tk = !($signed(a) < $signed(b));
                    3'd6: tk = (a < b);
                    3'd7: tk = !(a < b);
                    default: tk = 0;
                endcase
                if (tk) nxt = m_pc + immb;
            end
            7'h03: if (f3 == 3'd2) begin
                addr = a + immi;
                res = ((addr >> 2) < DW) ? m_mem[addr >> 2] : 32'h0;
                wr = 1;
            end
            7'h23: if (f3 == 3'd2) begin
                addr = a + imms;
                if ((addr >> 2) < DW) m_mem[addr >> 2] = b;
            end
            7'h13: begin
                wr = 1;
                case (f3)
                    3'd0: res = a + immi;
                    3'd1: if (f7 == 0) res = a << immi[4:0]; else wr = 0;
                    3'd2: res = ($signed(a) < $signed(immi)) ? 1 : 0;
                    3'd3: res = (a < immi) ? 1 : 0;
                    3'd4: res = a ^ immi;
                    3'd5: begin
                        if (f7 == 7'h00) res = a >> immi[4:0];
                        else if (f7 == 7'h20) res = $signed(a) >>> immi[4:0];
                        else wr = 0;
                    end
                    3'd6: res = a | immi;
                    default: res = a & immi;
                endcase
            end
            7'h33: begin
                if (f7 == 7'h00) begin
                    wr = 1;
                    case (f3)
                        3'd0: res = a + b;
                        3'd1: res = a << b[4:0];
                        3'd2: res = ($signed(a) < $signed(b)) ? 1 : 0;
                        3'd3: res = (a < b) ? 1 : 0;
                        3'd4: res = a ^ b;
                        3'd5: res = a >> b[4:0];
                        3'd6: res = a | b;
                        default: res = a & b;
                    endcase
                end else if (f7 == 7'h20 && f3 == 3'd0) begin
                    wr = 1; res = a - b;
                end else if (f7 == 7'h20 && f3 == 3'd5) begin
                    wr = 1; res = $signed(a) >>> b[4:0];
                end
`ifdef RV_MUL_EN
                else if (f7 == 7'h01 && f3 < 3'd4) begin
                    wr = 1;
                    case (f3)
                        3'd0: begin up = 64'(a) * 64'(b); res = up[31:0]; end
                        3'd1: begin
                            sp = longint'($signed(a)) * longint'($signed(b)); res = sp[63:32];
                        end
                        3'd2: begin
                            sp = longint'($signed(a)) * longint'({32'h0, b}); res = sp[63:32];
                        end
                        default: begin up = 64'(a) * 64'(b); res = up[63:32]; end
                    endcase
                end
`endif
            end
            default: ;
        endcase
        if (wr && rd != 5'd0) m_x[rd] = res;
        m_pc = nxt;
    endtask

    task automatic load_prog();
        for (int i = 0; i < IW; i++) begin
            img[i] = (i < prog.size()) ? prog[i] : 32'h0;
            dut.imem[i] = img[i];
        end
        prog.delete();
    endtask

    // Load the pending program under reset, then release on a falling edge.
    task automatic start_prog();
        rst = 1'b1;
        load_prog();
        m_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic step_both();
        m_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        prog.push_back(32'h00500093);
        rst = 1'b1;
        load_prog();
        m_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (instr1 !== 32'h00500093) begin
                n_errors++; $display("FAIL reset_instr cyc %0d: got %h want 00500093", c, instr1);
            end
            n_checks++;
            if (regs !== '0) begin
                n_errors++; $display("FAIL reset_regs cyc %0d: x1=%h want all zero", c, regs[1]);
            end
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (regs[1] !== 32'd5) begin
            n_errors++; $display("FAIL reset_first_exec: x1=%h want 00000005", regs[1]);
        end
        n_checks++;
        if (instr1 !== 32'h0) begin
            n_errors++; $display("FAIL reset_next_fetch: got %h want 00000000", instr1);
        end
    endtask

    task automatic test_alu();
        int d;
        prog.push_back(enc_i(-1, 0, 0, 1, 7'h13));
        prog.push_back(enc_i(1, 0, 0, 2, 7'h13));
        prog.push_back(enc_r(0, 2, 1, 0, 3));
        prog.push_back(enc_r(0, 1, 2, 3, 4));
        prog.push_back(enc_i(32'h404, 1, 5, 5, 7'h13));
        prog.push_back(32'h0);
        start_prog();
        for (int c = 0; c < 7; c++) begin
            n_checks++;
            if (instr1 !== m_fetch()) begin
                n_errors++; $display("FAIL alu_instr cyc %0d: got %h want %h", c, instr1, m_fetch());
            end
            step_both();
            d = first_diff();
            n_checks++;
            if (d >= 0) begin
                n_errors++;
                $display("FAIL alu_regs cyc %0d: x%0d=%h want %h", c, d, regs[d], m_x[d]);
            end
        end
        n_checks++;
        if ({regs[3], regs[4], regs[5]} !== {32'h0, 32'h1, 32'hFFFF_FFFF}) begin
            n_errors++;
            $display("FAIL alu_result: x3=%h x4=%h x5=%h want 0 1 ffffffff",
                     regs[3], regs[4], regs[5]);
        end
    endtask

    task automatic test_mem();
        int d;
        prog.push_back(enc_u(32'h12345, 1, 7'h37));
        prog.push_back(enc_s(8, 1, 0, 2));
        prog.push_back(enc_i(8, 0, 2, 2, 7'h03));
        prog.push_back(enc_i(7, 0, 0, 0, 7'h13));
        prog.push_back(enc_i(1024, 0, 0, 3, 7'h13));
        prog.push_back(enc_s(0, 1, 3, 2));
        prog.push_back(enc_i(0, 3, 2, 4, 7'h03));
        prog.push_back(enc_i(10, 0, 2, 5, 7'h03));
        prog.push_back(32'h0);
        start_prog();
        for (int c = 0; c < 10; c++) begin
            step_both();
            d = first_diff();
            n_checks++;
            if (d >= 0) begin
                n_errors++;
                $display("FAIL mem_regs cyc %0d: x%0d=%h want %h", c, d, regs[d], m_x[d]);
            end
        end
        n_checks++;
        if ({regs[0], regs[2], regs[4], regs[5]} !== {32'h0, 32'h1234_5000, 32'h0, 32'h1234_5000})
        begin
            n_errors++;
            $display("FAIL mem_result: x0=%h x2=%h x4=%h x5=%h want 0 12345000 0 12345000",
                     regs[0], regs[2], regs[4], regs[5]);
        end
    endtask

    task automatic test_control();
        int d;
        prog.push_back(enc_i(3, 0, 0, 1, 7'h13));
        prog.push_back(enc_i(-1, 1, 0, 1, 7'h13));
        prog.push_back(enc_b(-4, 0, 1, 1));
        prog.push_back(enc_j(8, 2));
        prog.push_back(enc_i(99, 0, 0, 3, 7'h13));
        prog.push_back(enc_i(29, 0, 0, 4, 7'h67));
        prog.push_back(enc_i(55, 0, 0, 3, 7'h13));
        prog.push_back(32'h0);
        start_prog();
        for (int c = 0; c < 12; c++) begin
            n_checks++;
            if (instr1 !== m_fetch()) begin
                n_errors++; $display("FAIL ctl_instr cyc %0d: got %h want %h", c, instr1, m_fetch());
            end
            step_both();
            d = first_diff();
            n_checks++;
            if (d >= 0) begin
                n_errors++;
                $display("FAIL ctl_regs cyc %0d: x%0d=%h want %h", c, d, regs[d], m_x[d]);
            end
        end
        n_checks++;
        if ({regs[1], regs[2], regs[3], regs[4]} !== {32'd0, 32'd16, 32'd0, 32'd24}) begin
            n_errors++;
            $display("FAIL ctl_result: x1=%h x2=%h x3=%h x4=%h want 0 10 0 18",
                     regs[1], regs[2], regs[3], regs[4]);
        end
    endtask

    task automatic test_halt();
        prog.push_back(enc_i(1, 0, 0, 5, 7'h13));
        prog.push_back(enc_i(2, 0, 0, 6, 7'h13));
        prog.push_back(32'h0);
        prog.push_back(enc_i(77, 0, 0, 5, 7'h13));
        prog.push_back(enc_i(9, 0, 0, 7, 7'h13));
        start_prog();
        repeat (2) step_both();
        for (int c = 0; c < 6; c++) begin
            n_checks++;
            if (instr1 !== 32'h0) begin
                n_errors++; $display("FAIL halt_instr cyc %0d: got %h want 00000000", c, instr1);
            end
            step_both();
            n_checks++;
            if ({regs[5], regs[6], regs[7]} !== {32'd1, 32'd2, 32'd0}) begin
                n_errors++;
                $display("FAIL halt_regs cyc %0d: x5=%h x6=%h x7=%h want 1 2 0",
                         c, regs[5], regs[6], regs[7]);
            end
        end
        for (int i = 0; i < 32; i += 4)
            $display("x%0d=%h x%0d=%h x%0d=%h x%0d=%h", i, regs[i], i + 1, regs[i + 1],
                     i + 2, regs[i + 2], i + 3, regs[i + 3]);
    endtask

    task automatic test_mul();
        int d;
        logic [31:0] e3, e4, e5, e6;
`ifdef RV_MUL_EN
        e3 = 32'hFFFF_FFFA; e4 = 32'h2; e5 = 32'hFFFF_FFFF; e6 = 32'hFFFF_FFFF;
`else
        e3 = 32'h0; e4 = 32'h0; e5 = 32'h0; e6 = 32'h0;
`endif
        prog.push_back(enc_i(-2, 0, 0, 1, 7'h13));
        prog.push_back(enc_i(3, 0, 0, 2, 7'h13));
        prog.push_back(enc_r(1, 2, 1, 0, 3));
        prog.push_back(enc_r(1, 2, 1, 3, 4));
        prog.push_back(enc_r(1, 2, 1, 1, 5));
        prog.push_back(enc_r(1, 2, 1, 2, 6));
        prog.push_back(enc_r(1, 2, 1, 4, 7));
        prog.push_back(32'h0);
        start_prog();
        for (int c = 0; c < 9; c++) begin
            step_both();
            d = first_diff();
            n_checks++;
            if (d >= 0) begin
                n_errors++;
                $display("FAIL mul_regs cyc %0d: x%0d=%h want %h", c, d, regs[d], m_x[d]);
            end
        end
        n_checks++;
        if ({regs[3], regs[4], regs[5], regs[6], regs[7]} !== {e3, e4, e5, e6, 32'h0}) begin
            n_errors++;
            $display("FAIL mul_result: x3..x7=%h %h %h %h %h want %h %h %h %h 0",
                     regs[3], regs[4], regs[5], regs[6], regs[7], e3, e4, e5, e6);
        end
    endtask

    task automatic test_random();
        int d, n;
        logic [31:0] f7, f3, imm;
        for (int round = 0; round < 4; round++) begin
            for (int r = 1; r < 8; r++) begin
                prog.push_back(enc_u($urandom, r, 7'h37));
                prog.push_back(enc_i($urandom, r, 0, r, 7'h13));
            end
            for (int k = 0; k < 30; k++) begin
                case ($urandom_range(0, 3))
                    0: f7 = 32'h00;
                    1: f7 = 32'h20;
                    2: f7 = 32'h01;
                    default: f7 = $urandom;
                endcase
                f3 = $urandom_range(0, 7);
                case ($urandom_range(0, 5))
                    0, 1: prog.push_back(enc_r(f7, $urandom_range(0, 7), $urandom_range(0, 7),
                                               f3, $urandom_range(0, 7)));
                    2: begin
                        imm = (f3 == 1 || f3 == 5) ? {20'h0, f7[6:0], 5'($urandom)} : $urandom;
                        prog.push_back(enc_i(imm, $urandom_range(0, 7), f3,
                                             $urandom_range(0, 7), 7'h13));
                    end
                    3: prog.push_back(enc_s($urandom_range(0, 2047), $urandom_range(0, 7),
                                            ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : 0,
                                            ($urandom_range(0, 4) == 0) ? f3 : 2));
                    4: prog.push_back(enc_i($urandom_range(0, 2047),
                                            ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : 0,
                                            ($urandom_range(0, 4) == 0) ? f3 : 2,
                                            $urandom_range(0, 7), 7'h03));
                    default: prog.push_back(enc_b(8, $urandom_range(0, 7), $urandom_range(0, 7),
                                                  f3));
                endcase
            end
            prog.push_back(32'h0);
            n = prog.size() + 2;
            start_prog();
            for (int c = 0; c < n; c++) begin
                n_checks++;
                if (instr1 !== m_fetch()) begin
                    n_errors++;
                    $display("FAIL rnd_instr r%0d cyc %0d: got %h want %h",
                             round, c, instr1, m_fetch());
                end
                step_both();
                d = first_diff();
                n_checks++;
                if (d >= 0) begin
                    n_errors++;
                    $display("FAIL rnd_regs r%0d cyc %0d: x%0d=%h want %h",
                             round, c, d, regs[d], m_x[d]);
                end
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_alu();
        test_mem();
        test_control();
        test_halt();
        test_mul();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
